mult_div_sequencer: RTL and testbench

//  Multi-cycle controller/datapath for the MULT/DIV ALU opcodes (Cntrl 4'b1110/4'b1111).

---
 rtl/mult_div_sequencer.sv | 164 ++++++++++++++++
 tb/tb_mult_div_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_sequencer.sv
// rtl/mult_div_sequencer.sv - iterative shift-add multiply / restoring divide sequencer for MULT/DIV opcodes
// Results land in HI/LO together with a one-cycle done pulse; Busy stalls the control FSM.
module mult_div_sequencer #(
    parameter int OPERAND_WIDTH = 32
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [OPERAND_WIDTH-1:0] Operand1,
    input  logic [OPERAND_WIDTH-1:0] Operand2,
    input  logic                     Signed_Op,
    input  logic                     mult_start,
    input  logic                     div_start,
    output logic [OPERAND_WIDTH-1:0] HI_OUT,
    output logic [OPERAND_WIDTH-1:0] LO_OUT,
    output logic                     Busy,
    output logic                     mult_div_done,
    output logic                     DZ_OUT
);
    localparam int N  = OPERAND_WIDTH;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_SIGN, S_DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    acc_q, sh_q, opd_q;
    logic [N-1:0]    res_hi_q, res_lo_q;
    logic [N-1:0]    hi_q, lo_q;
    logic            is_mult_q, neg_res_q, neg_rem_q, dz_pend_q;
    logic            busy_q, done_q, dz_q;

    logic            sign1, sign2;
    logic [N-1:0]    mag1, mag2;
    logic [N:0]      mul_sum;
    logic [N-1:0]    mul_acc_d, mul_sh_d;
    logic [N-1:0]    div_low, div_sub, div_acc_d, div_sh_d;
    logic            div_ge;
    logic [2*N-1:0]  prod_fix;
    logic [N-1:0]    quo_fix, rem_fix;

    always_comb begin
        sign1 = Signed_Op & Operand1[N-1];
        sign2 = Signed_Op & Operand2[N-1];
        // -(-2^(N-1)) wraps back to 2^(N-1), which is the correct N-bit unsigned magnitude
        mag1  = sign1 ? -Operand1 : Operand1;
        mag2  = sign2 ? -Operand2 : Operand2;

        // Multiply: {acc,sh} is the partial product, sh initially holds the multiplier
        mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opd_q} : '0);
        mul_acc_d = mul_sum[N:1];
        mul_sh_d  = {mul_sum[0], sh_q[N-1:1]};

        // Divide: shifted remainder is N+1 bits; a set top bit always exceeds the divisor
        div_low   = {acc_q[N-2:0], sh_q[N-1]};
        div_ge    = acc_q[N-1] | (div_low >= opd_q);
        div_sub   = div_low - opd_q;
        div_acc_d = div_ge ? div_sub : div_low;
        div_sh_d  = {sh_q[N-2:0], div_ge};

        prod_fix  = neg_res_q ? -{acc_q, sh_q} : {acc_q, sh_q};
        quo_fix   = neg_res_q ? -sh_q : sh_q;
        rem_fix   = neg_rem_q ? -acc_q : acc_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            opd_q     <= '0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_mult_q <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mult_start) begin
                        acc_q     <= '0;
                        sh_q      <= mag2;
                        opd_q     <= mag1;
                        cnt_q     <= CW'(N);
                        neg_res_q <= sign1 ^ sign2;
                        neg_rem_q <= 1'b0;
                        is_mult_q <= 1'b1;
                        dz_pend_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_MULT;
                    end else if (div_start) begin
                        busy_q    <= 1'b1;
                        is_mult_q <= 1'b0;
                        if (Operand2 == '0) begin
                            res_hi_q  <= Operand1;
                            res_lo_q  <= '1;
                            dz_pend_q <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            acc_q     <= '0;
                            sh_q      <= mag1;
                            opd_q     <= mag2;
                            cnt_q     <= CW'(N);
                            neg_res_q <= sign1 ^ sign2;
                            neg_rem_q <= sign1;
                            dz_pend_q <= 1'b0;
                            state_q   <= S_DIV;
                        end
                    end
                end
                S_MULT: begin
                    acc_q <= mul_acc_d;
                    sh_q  <= mul_sh_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= S_SIGN;
                end
                S_DIV: begin
                    acc_q <= div_acc_d;
                    sh_q  <= div_sh_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= S_SIGN;
                end
                S_SIGN: begin
                    if (is_mult_q) begin
                        res_hi_q <= prod_fix[2*N-1:N];
                        res_lo_q <= prod_fix[N-1:0];
                    end else begin
                        res_hi_q <= rem_fix;
                        res_lo_q <= quo_fix;
                    end
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    // HI/LO are only published here so they never expose a pending result early
                    hi_q    <= res_hi_q;
                    lo_q    <= res_lo_q;
                    done_q  <= 1'b1;
                    dz_q    <= dz_pend_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign HI_OUT        = hi_q;
    assign LO_OUT        = lo_q;
    assign Busy          = busy_q;
    assign mult_div_done = done_q;
    assign DZ_OUT        = dz_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb/tb_mult_div_sequencer.sv - scoreboard bench for mult_div_sequencer
module tb_mult_div_sequencer;
    localparam int N = 32;

    typedef struct packed {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         dz;
    } res_t;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [N-1:0] Operand1 = '0;
    logic [N-1:0] Operand2 = '0;
    logic         Signed_Op = 1'b0;
    logic         mult_start = 1'b0;
    logic         div_start = 1'b0;
    logic [N-1:0] HI_OUT, LO_OUT;
    logic         Busy, mult_div_done, DZ_OUT;

    int   errors = 0;
    int   checks = 0;
    int   n_done = 0;
    int   n_ops  = 0;
    res_t sb_q[$];
    res_t exp_r;

    mult_div_sequencer #(.OPERAND_WIDTH(N)) dut (
        .CLK(CLK), .RST_N(RST_N), .Operand1(Operand1), .Operand2(Operand2),
        .Signed_Op(Signed_Op), .mult_start(mult_start), .div_start(div_start),
        .HI_OUT(HI_OUT), .LO_OUT(LO_OUT), .Busy(Busy),
        .mult_div_done(mult_div_done), .DZ_OUT(DZ_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic res_t model(input bit is_mult, input logic [N-1:0] a, input logic [N-1:0] b,
                                   input bit sgn);
        res_t        r;
        longint      sa, sb, q, rm;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.dz = 1'b0;
        if (is_mult) begin
            if (sgn) p = sa * sb;
            else     p = {32'b0, a} * {32'b0, b};
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (b == '0) begin
            r.hi = a;
            r.lo = '1;
            r.dz = 1'b1;
        end else if (sgn) begin
            q  = sa / sb;
            rm = sa % sb;
            r.lo = 32'(q);
            r.hi = 32'(rm);
        end else begin
            r.lo = a / b;
            r.hi = a % b;
        end
        return r;
    endfunction

    always @(negedge CLK) begin
        if (mult_div_done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(1), 64'(0));
            end else begin
                exp_r = sb_q.pop_front();
                check("hi", 64'(HI_OUT), 64'(exp_r.hi));
                check("lo", 64'(LO_OUT), 64'(exp_r.lo));
                check("dz", 64'(DZ_OUT), 64'(exp_r.dz));
                n_done++;
            end
        end else if (DZ_OUT) begin
            check("dz_without_done", 64'(DZ_OUT), 64'(0));
        end
    end

    task automatic do_op(input bit is_mult, input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit sgn, input bit hold_div);
        int           n;
        int           exp_lat;
        bit           busy_all, stable;
        logic [N-1:0] prev_hi, prev_lo;
        @(negedge CLK);
        prev_hi    = HI_OUT;
        prev_lo    = LO_OUT;
        Operand1   = a;
        Operand2   = b;
        Signed_Op  = sgn;
        mult_start = is_mult;
        div_start  = !is_mult || hold_div;
        sb_q.push_back(model(is_mult, a, b, sgn));
        n_ops++;
        exp_lat = (!is_mult && b == '0) ? 1 : N + 2;
        @(posedge CLK);
        #1;
        mult_start = 1'b0;
        div_start  = hold_div;
        Operand1   = $urandom;
        Operand2   = $urandom;
        n = 0;
        busy_all = Busy;
        stable   = (HI_OUT == prev_hi) && (LO_OUT == prev_lo);
        while (!mult_div_done && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
            if (!mult_div_done) begin
                busy_all &= Busy;
                stable   &= (HI_OUT == prev_hi) && (LO_OUT == prev_lo);
            end
        end
        div_start = 1'b0;
        if (!mult_div_done) begin
            check("done_timeout", 64'(0), 64'(1));
        end else begin
            check("latency", 64'(n), 64'(exp_lat));
            check("busy_while_running", 64'(busy_all), 64'(1));
            check("busy_low_at_done", 64'(Busy), 64'(0));
            check("hilo_held_until_done", 64'(stable), 64'(1));
            if (hold_div) begin
                @(posedge CLK);
                #1;
                check("div_request_dropped", 64'(Busy), 64'(0));
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("rst_hi", 64'(HI_OUT), 64'(0));
        check("rst_lo", 64'(LO_OUT), 64'(0));
        check("rst_busy", 64'(Busy), 64'(0));
        check("rst_done", 64'(mult_div_done), 64'(0));
        check("rst_dz", 64'(DZ_OUT), 64'(0));
        @(negedge CLK);
        RST_N = 1'b1;

        do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(1'b1, 32'hFFFF_FFFD, 32'd7,         1'b1, 1'b0);
        do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        do_op(1'b0, 32'hFFFF_FFF9, 32'd2,         1'b1, 1'b0);
        do_op(1'b0, 32'd100,       32'd7,         1'b0, 1'b0);
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op(1'b0, 32'd5,         32'd0,         1'b0, 1'b0);
        do_op(1'b0, 32'd13,        32'hFFFF_FFFC, 1'b1, 1'b0);
        do_op(1'b0, 32'd5,         32'd0,         1'b1, 1'b0);
        do_op(1'b1, 32'd6,         32'd9,         1'b0, 1'b0);
        do_op(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            do_op(i[0], $urandom, (i == 5) ? 32'd0 : $urandom, i[1], 1'b0);
        end

        // Abort a multiply mid-flight with an asynchronous reset
        @(negedge CLK);
        Operand1   = 32'hFFFF_FFFF;
        Operand2   = 32'h1234_5678;
        Signed_Op  = 1'b0;
        mult_start = 1'b1;
        @(posedge CLK);
        #1;
        mult_start = 1'b0;
        repeat (10) @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        check("abort_hi", 64'(HI_OUT), 64'(0));
        check("abort_lo", 64'(LO_OUT), 64'(0));
        check("abort_busy", 64'(Busy), 64'(0));
        check("abort_done", 64'(mult_div_done), 64'(0));
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (40) @(posedge CLK);
        #1;
        check("no_done_after_abort", 64'(n_done), 64'(n_ops));
        do_op(1'b1, 32'd1000, 32'hFFFF_FFFE, 1'b1, 1'b0);

        repeat (2) @(posedge CLK);
        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        check("done_count", 64'(n_done), 64'(n_ops));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
